// File: rtl/mp8_control_unit.sv
// mp8_control_unit: fetch/decode/execute sequencer for the MP-8 accumulator CPU.
module mp8_control_unit #(
  parameter int              ADDR_W   = 5,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mem_ready,
  input  logic [7:0]          mem_rdata,
  input  logic                zero,
  input  logic                pos,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_re,
  output logic                mem_we,
  output logic                acc_load,
  output logic                acc_src,
  output logic [1:0]          alu_sel,
  output logic [ADDR_W-1:0]   pc,
  output logic [ADDR_W+2:0]   ir,
  output logic                halted,
  output logic                instr_done
);
  localparam int IW = 3 + ADDR_W;
  typedef enum logic [1:0] {FETCH, DECODE, EXEC} state_t;
  localparam logic [2:0] OP_STORE = 3'b001, OP_ADD = 3'b010, OP_SUB = 3'b011, OP_AND = 3'b100;
  localparam logic [2:0] OP_JMP = 3'b101, OP_JZ = 3'b110, OP_JPOS = 3'b111;
  state_t            state_q;
  logic              run_q;
  logic [ADDR_W-1:0] pc_q;
  logic [IW-1:0]     ir_q;
  logic              halted_q;
  logic [2:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic              is_jump, taken, fetch, exec, is_read, is_alu;
  assign opcode  = ir_q[IW-1:ADDR_W];
  assign operand = ir_q[ADDR_W-1:0];
  assign is_jump = opcode == OP_JMP || opcode == OP_JZ || opcode == OP_JPOS;
  assign taken   = opcode == OP_JMP || (opcode == OP_JZ && zero) || (opcode == OP_JPOS && pos);
  assign is_read = opcode != OP_STORE;
  assign is_alu  = opcode == OP_ADD || opcode == OP_SUB || opcode == OP_AND;
  // run_q holds strobes quiet for the first cycle after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FETCH;
      run_q    <= 1'b0;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      halted_q <= 1'b0;
    end else if (!run_q) begin
      run_q <= 1'b1;
    end else begin
      case (state_q)
        FETCH: if (mem_ready) begin
          ir_q    <= IW'(mem_rdata);
          pc_q    <= pc_q + ADDR_W'(1);
          state_q <= DECODE;
        end
        DECODE: if (is_jump) begin
          if (taken) pc_q <= operand;
          if (opcode == OP_JMP && operand == pc_q - ADDR_W'(1)) halted_q <= 1'b1;
          state_q <= FETCH;
        end else begin
          state_q <= EXEC;
        end
        EXEC: if (mem_ready) state_q <= FETCH;
        default: state_q <= FETCH;
      endcase
    end
  end
  assign fetch      = run_q && state_q == FETCH;
  assign exec       = state_q == EXEC;
  assign mem_addr   = exec ? operand : pc_q;
  assign mem_re     = fetch || (exec && is_read);
  assign mem_we     = exec && !is_read;
  assign acc_load   = exec && is_read && mem_ready;
  assign acc_src    = exec && is_alu;
  assign alu_sel    = !exec ? 2'b00 : opcode == OP_SUB ? 2'b01 : opcode == OP_AND ? 2'b10 : 2'b00;
  assign instr_done = (state_q == DECODE && is_jump) || (exec && mem_ready);
  assign pc         = pc_q;
  assign ir         = ir_q;
  assign halted     = halted_q;
endmodule

// File: doc/mp8_control_unit.md
Name: mp8_control_unit

Overview:
- Multi-cycle fetch/decode/execute controller for the MP-8 8-bit accumulator processor.
- Sits directly upstream of the ALU and downstream of its flags.
- Drives the ALU operation select, accumulator load/source, memory address/strobes, PC and IR.
- Consumes the ALU zero/pos flags (which reflect the accumulator) to resolve JZ/JPOS.

Parameters:
- ADDR_W, 5, address width. The instruction word is 3-bit opcode + ADDR_W-bit operand address, 8 bits at default.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_ready  in  1  memory handshake; access completes in any cycle where a strobe and mem_ready are both high
- mem_rdata  in  8  memory read data, valid when mem_re && mem_ready
- zero  in  1  ALU flag, accumulator == 0
- pos  in  1  ALU flag, accumulator > 0 (unsigned)
- mem_addr  out  ADDR_W  memory address
- mem_re  out  1  read strobe
- mem_we  out  1  write strobe; datapath writes the accumulator
- acc_load  out  1  accumulator load enable, one cycle
- acc_src  out  1  0 = mem_rdata (LOAD), 1 = ALU out
- alu_sel  out  2  00 ADD, 01 SUB, 10 AND; 00 when idle
- pc  out  ADDR_W  program counter
- ir  out  3+ADDR_W  instruction register
- halted  out  1  sticky self-jump detected
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction

Behaviour:
- Opcodes, ir[7:5]:
  - 000 LOAD, 001 STORE, 010 ADD, 011 SUB, 100 AND
  - 101 JMP, 110 JZ, 111 JPOS
  - operand = ir[ADDR_W-1:0]
- Reset (async, any state): state=FETCH, pc=RESET_PC, ir=0, halted=0. All strobes, acc_load and instr_done are 0; alu_sel=00; acc_src=0.
- Outputs are decoded from registered state/ir only; there is no combinational path from mem_rdata to strobes.
- FETCH:
  - mem_addr=pc, mem_re=1.
  - If mem_ready: ir<=mem_rdata, pc<=pc+1 (wraps mod 2^ADDR_W, e.g. 31 -> 0), go to DECODE.
  - Else hold: pc and ir unchanged.
- DECODE (always 1 cycle, no strobes; flags sampled here, after the last accumulator update):
  - JMP: pc<=operand.
  - JZ: pc<=operand if zero, else pc unchanged.
  - JPOS: pc<=operand if pos, else pc unchanged.
  - Jumps then go to FETCH with instr_done=1.
  - Other opcodes go to EXEC.
  - JMP whose operand == pc-1 (address of itself) sets halted. It keeps looping; halted clears only on reset.
  - A taken JZ/JPOS to itself does not set halted.
- EXEC: mem_addr=operand.
  - STORE: mem_we=1.
  - LOAD/ADD/SUB/AND: mem_re=1.
  - ADD/SUB/AND: alu_sel per opcode, acc_src=1. LOAD: acc_src=0.
  - acc_load=mem_ready (read ops only).
  - On mem_ready: instr_done=1, go to FETCH. Else stay, holding all outputs.
- Latency with mem_ready tied high: jumps 2 cycles; LOAD/STORE/ALU ops 3 cycles. Each wait cycle adds 1.
- mem_re and mem_we are never high together; acc_load is never high outside EXEC.
- Reset mid-EXEC aborts the instruction: no acc_load or mem_we after rst_n falls.

Test Plan:
- Reset: rst_n low mid-FETCH with mem_ready=1 -> pc=0, ir=0, all strobes 0 immediately (async); first FETCH drives mem_addr=0, mem_re=1 on the first edge after release.
- Program with mem_ready=1: mem[0..3] = 0x0A (LOAD 10), 0x4B (ADD 11), 0x2C (STORE 12), 0xA3 (JMP 3); mem[10]=5, mem[11]=7. Required response:
  - bench acc = 12 and mem[12] = 12
  - LOAD/ADD/STORE take 3 cycles each
  - halted rises in the DECODE of the JMP at address 3
- Branches: acc=0 with JZ 20 (0xD4) -> pc=20. acc=0 with JPOS 20 (0xF4) -> not taken, pc = instr addr+1. acc=3 with JPOS 20 -> pc=20.
- Wait states: mem_ready low for 3 cycles in FETCH and 2 in EXEC of SUB 9 (0x69) -> outputs held stable, alu_sel=01 throughout EXEC, acc_load only in the ready cycle, 8 cycles total.
- PC wrap: with RESET_PC=31, fetch of a non-jump at address 31 -> pc=0 next.
- Reset mid-EXEC of STORE with mem_ready=0 -> mem_we drops immediately, no write occurs, restart at RESET_PC.
